// File: rtl/pixel_sched.sv
// Fixed-priority scheduler sharing one pixel output register among restore, fill and freehand.
// Define PIXEL_SCHED_AGING_EN to let a starved freehand request break through a fill lock.
module pixel_sched #(
  parameter int unsigned AGE_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_req,
  input  logic [7:0] rst_x,
  input  logic [7:0] rst_y,
  input  logic [2:0] rst_color,
  output logic       rst_gnt,
  input  logic       fill_req,
  input  logic       fill_busy,
  input  logic [7:0] fill_x,
  input  logic [7:0] fill_y,
  input  logic [2:0] fill_color,
  output logic       fill_gnt,
  input  logic       free_req,
  input  logic [7:0] free_x,
  input  logic [7:0] free_y,
  input  logic [2:0] free_color,
  output logic       free_gnt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_x,
  output logic [7:0] out_y,
  output logic [2:0] out_color,
  output logic [1:0] out_src,
  output logic       lock_active
);

  if (AGE_LIMIT < 1 || AGE_LIMIT > 255) begin : g_age_range
    $error("pixel_sched: AGE_LIMIT must be in 1..255");
  end

  typedef enum logic {IDLE, LOCK_FILL} state_t;

  state_t     state, state_nxt;
  logic       slot_open;
  logic       any_gnt;
  logic [7:0] sel_x, sel_y;
  logic [2:0] sel_color;
  logic [1:0] sel_src;

  assign slot_open   = !out_valid || out_ready;
  assign any_gnt     = rst_gnt || fill_gnt || free_gnt;
  assign lock_active = (state == LOCK_FILL);

`ifdef PIXEL_SCHED_AGING_EN
  localparam logic [7:0] AGE_MAX = 8'(AGE_LIMIT);
  logic [7:0] age;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else if (state == IDLE || !free_req || free_gnt) begin
      age <= '0;
    end else if (age != AGE_MAX) begin
      age <= age + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grants are masked during reset so every grant reads 0 while rst is high.
  always_comb begin
    rst_gnt   = 1'b0;
    fill_gnt  = 1'b0;
    free_gnt  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (slot_open && !rst) begin
          if (rst_req)       rst_gnt  = 1'b1;
          else if (fill_req) fill_gnt = 1'b1;
          else if (free_req) free_gnt = 1'b1;
        end
        if (fill_gnt && fill_busy) state_nxt = LOCK_FILL;
      end
      LOCK_FILL: begin
        if (slot_open && !rst) begin
`ifdef PIXEL_SCHED_AGING_EN
          if (age == AGE_MAX && free_req) free_gnt = 1'b1;
          else if (fill_req)              fill_gnt = 1'b1;
`else
          if (fill_req) fill_gnt = 1'b1;
`endif
        end
        if (!fill_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_x     = rst_x;
    sel_y     = rst_y;
    sel_color = rst_color;
    sel_src   = 2'd0;
    if (fill_gnt) begin
      sel_x     = fill_x;
      sel_y     = fill_y;
      sel_color = fill_color;
      sel_src   = 2'd1;
    end else if (free_gnt) begin
      sel_x     = free_x;
      sel_y     = free_y;
      sel_color = free_color;
      sel_src   = 2'd2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_color <= '0;
      out_src   <= '0;
    end else if (any_gnt) begin
      out_valid <= 1'b1;
      out_x     <= sel_x;
      out_y     <= sel_y;
      out_color <= sel_color;
      out_src   <= sel_src;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_sched.sv
// Directed bench for pixel_sched with AGE_LIMIT=4; expectations follow PIXEL_SCHED_AGING_EN.
module tb_pixel_sched;

  logic       clk, rst;
  logic       rst_req, fill_req, fill_busy, free_req, out_ready;
  logic [7:0] rst_x, rst_y, fill_x, fill_y, free_x, free_y;
  logic [2:0] rst_color, fill_color, free_color;
  logic       rst_gnt, fill_gnt, free_gnt, out_valid, lock_active;
  logic [7:0] out_x, out_y;
  logic [2:0] out_color;
  logic [1:0] out_src;

  int n_cmp = 0;
  int n_err = 0;

  pixel_sched #(.AGE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .rst_req(rst_req), .rst_x(rst_x), .rst_y(rst_y), .rst_color(rst_color), .rst_gnt(rst_gnt),
    .fill_req(fill_req), .fill_busy(fill_busy), .fill_x(fill_x), .fill_y(fill_y),
    .fill_color(fill_color), .fill_gnt(fill_gnt),
    .free_req(free_req), .free_x(free_x), .free_y(free_y), .free_color(free_color),
    .free_gnt(free_gnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_color(out_color), .out_src(out_src), .lock_active(lock_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    {rst_req, fill_req, fill_busy, free_req, out_ready} = '0;
    {rst_x, rst_y, fill_x, fill_y, free_x, free_y} = '0;
    {rst_color, fill_color, free_color} = '0;
    #2;
    check("reset_valid", out_valid, 0);
    check("reset_xy", {out_x, out_y}, 0);
    check("reset_color_src", {out_color, out_src}, 0);
    check("reset_lock", lock_active, 0);
    check("reset_gnts", {rst_gnt, fill_gnt, free_gnt}, 0);
    tick(); tick();
    rst = 1'b0;

    // Single freehand pixel
    tick(); free_req = 1; free_x = 10; free_y = 20; free_color = 5; out_ready = 1;
    settle();
    check("t1_free_gnt", {rst_gnt, fill_gnt, free_gnt}, 3'b001);
    check("t1_valid_before", out_valid, 0);
    tick(); free_req = 0;
    settle();
    check("t1_valid", out_valid, 1);
    check("t1_xy", {out_x, out_y}, {8'd10, 8'd20});
    check("t1_color", out_color, 5);
    check("t1_src", out_src, 2);
    tick(); settle();
    check("t1_drain", out_valid, 0);
    check("t1_hold_x", out_x, 10);

    // Fixed priority with all three requesting
    tick();
    rst_req = 1; rst_x = 1; rst_y = 2; rst_color = 3;
    fill_req = 1; fill_busy = 0; fill_x = 4; fill_y = 5; fill_color = 6;
    free_req = 1; free_x = 7; free_y = 8; free_color = 1;
    settle();
    check("t2_c1_gnts", {rst_gnt, fill_gnt, free_gnt}, 3'b100);
    tick(); rst_req = 0; settle();
    check("t2_c2_gnts", {rst_gnt, fill_gnt, free_gnt}, 3'b010);
    check("t2_c2_out", {out_src, out_x}, {2'd0, 8'd1});
    tick(); fill_req = 0; settle();
    check("t2_c3_gnts", {rst_gnt, fill_gnt, free_gnt}, 3'b001);
    check("t2_c3_out", {out_src, out_x}, {2'd1, 8'd4});
    check("t2_c3_lock", lock_active, 0);
    tick(); free_req = 0; settle();
    check("t2_c4_out", {out_src, out_x, out_color}, {2'd2, 8'd7, 3'd1});
    tick(); settle();

    // Fill lock holds off a restore until fill_busy falls
    tick(); fill_busy = 1; fill_req = 1; fill_x = 30; fill_y = 40; fill_color = 2;
    settle();
    check("t3_f1_gnt", fill_gnt, 1);
    check("t3_f1_lock", lock_active, 0);
    tick(); fill_x = 31; rst_req = 1; rst_x = 50; rst_y = 60; rst_color = 7;
    settle();
    check("t3_f2_gnts", {rst_gnt, fill_gnt, free_gnt}, 3'b010);
    check("t3_f2_lock", lock_active, 1);
    check("t3_f2_out", {out_src, out_x}, {2'd1, 8'd30});
    tick(); fill_x = 32; settle();
    check("t3_f3_gnts", {rst_gnt, fill_gnt, free_gnt}, 3'b010);
    check("t3_f3_out", out_x, 31);
    tick(); fill_x = 33; fill_busy = 0; settle();
    check("t3_f4_gnts", {rst_gnt, fill_gnt, free_gnt}, 3'b010);
    check("t3_f4_lock", lock_active, 1);
    check("t3_f4_out", out_x, 32);
    tick(); fill_req = 0; settle();
    check("t3_rst_gnt", {rst_gnt, fill_gnt, free_gnt}, 3'b100);
    check("t3_unlock", lock_active, 0);
    check("t3_f4_data", {out_src, out_x}, {2'd1, 8'd33});
    tick(); rst_req = 0; settle();
    check("t3_rst_data", {out_src, out_x, out_y, out_color}, {2'd0, 8'd50, 8'd60, 3'd7});
    tick(); settle();

    // Back-pressure
    tick(); out_ready = 0; free_req = 1; free_x = 100; free_y = 101; free_color = 4;
    settle();
    check("t4_free_gnt", free_gnt, 1);
    tick(); free_req = 0; rst_req = 1; rst_x = 9; rst_y = 9; rst_color = 3;
    settle();
    check("t4_stall0_gnt", rst_gnt, 0);
    check("t4_stall0_out", {out_valid, out_x}, {1'b1, 8'd100});
    for (int i = 1; i < 5; i++) begin
      tick(); settle();
      check("t4_stall_gnt", {rst_gnt, fill_gnt, free_gnt}, 3'b000);
      check("t4_stall_out", {out_valid, out_x, out_y, out_color}, {1'b1, 8'd100, 8'd101, 3'd4});
    end
    tick(); out_ready = 1; settle();
    check("t4_release_gnt", rst_gnt, 1);
    check("t4_release_old", out_x, 100);
    tick(); rst_req = 0; settle();
    check("t4_new_out", {out_valid, out_src, out_x, out_color}, {1'b1, 2'd0, 8'd9, 3'd3});
    tick(); settle();
    check("t4_drain", out_valid, 0);

    // Freehand held during a long fill lock
    tick(); fill_busy = 1; fill_req = 1; fill_x = 200; fill_y = 201; fill_color = 5;
    free_req = 1; free_x = 77; free_y = 88; free_color = 6;
    settle();
    check("t5_l0_gnts", {fill_gnt, free_gnt}, 2'b10);
    for (int i = 1; i <= 4; i++) begin
      tick(); settle();
      check("t5_wait_gnts", {fill_gnt, free_gnt}, 2'b10);
      check("t5_wait_lock", lock_active, 1);
    end
    tick(); settle();
`ifdef PIXEL_SCHED_AGING_EN
    check("t5_aged_gnts", {fill_gnt, free_gnt}, 2'b01);
    check("t5_aged_lock", lock_active, 1);
    tick(); free_req = 0; settle();
    check("t5_after_gnt", fill_gnt, 1);
    check("t5_after_lock", lock_active, 1);
    check("t5_free_out", {out_src, out_x, out_y}, {2'd2, 8'd77, 8'd88});
`else
    check("t5_noage_gnts", {fill_gnt, free_gnt}, 2'b10);
    tick(); fill_busy = 0; fill_req = 0; settle();
    check("t5_last_lock_gnt", free_gnt, 0);
    check("t5_last_lock", lock_active, 1);
    tick(); settle();
    check("t5_idle_gnt", free_gnt, 1);
    check("t5_idle_lock", lock_active, 0);
    tick(); free_req = 0; settle();
    check("t5_free_out", {out_src, out_x, out_y}, {2'd2, 8'd77, 8'd88});
`endif

    // Asynchronous reset with a held pixel and an active lock
    tick(); fill_req = 0; fill_busy = 0; free_req = 0; rst_req = 0; out_ready = 1;
    settle();
    tick(); fill_req = 1; fill_busy = 1; fill_x = 5; out_ready = 0; settle();
    check("t6_pre_gnt", fill_gnt, 1);
    tick(); settle();
    check("t6_pre_state", {out_valid, lock_active}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("t6_async_state", {out_valid, lock_active}, 2'b00);
    check("t6_async_data", {out_x, out_y, out_color, out_src}, 0);
    check("t6_async_gnt", {rst_gnt, fill_gnt, free_gnt}, 3'b000);
    tick(); rst = 0; fill_req = 0; fill_busy = 0; settle();
    check("t6_post", {out_valid, lock_active}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_sched.md
# pixel_sched

Scheduler that shares the single downstream pixel channel (packet generator / I2C pixel stream) among three pixel requesters: undo/redo restore, rectangle fill, and freehand cursor. It arbitrates by fixed priority, locks the channel to the fill engine for a whole rectangle so fill pixels are never interleaved, and holds the winning pixel in one output register with a valid/ready handshake. With aging compiled in, a fill lock cannot starve freehand drawing indefinitely.

## Interface
Parameters:
- AGE_LIMIT, 16, cycles a freehand request may wait during a fill lock before it is forced through (1..255)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rst_req  in  1  restore requester: pixel request (undo/redo)
- rst_x, rst_y  in  8 each  restore pixel coordinates
- rst_color  in  3  restore pixel colour
- rst_gnt  out  1  restore grant, one-cycle pulse
- fill_req  in  1  fill requester: pixel request
- fill_busy  in  1  fill engine mid-rectangle
- fill_x, fill_y  in  8 each  fill pixel coordinates
- fill_color  in  3  fill pixel colour
- fill_gnt  out  1  fill grant, one-cycle pulse
- free_req  in  1  freehand requester: pixel request
- free_x, free_y  in  8 each  freehand coordinates
- free_color  in  3  freehand colour
- free_gnt  out  1  freehand grant, one-cycle pulse
- out_valid  out  1  output register holds a pixel
- out_ready  in  1  downstream accepts pixel
- out_x, out_y  out  8 each  scheduled pixel
- out_color  out  3  scheduled colour
- out_src  out  2  source of held pixel: 0 restore, 1 fill, 2 freehand
- lock_active  out  1  state is LOCK_FILL

## Operation
- Requester rule: raise req with data stable; hold until gnt pulse; data sampled on the edge ending the gnt cycle. Deasserting req without a grant is legal (withdrawal).
- Capture slot open when out_valid==0 or out_ready==1. Grants are combinational and only issued while slot open; at most one gnt high per cycle.
- IDLE: priority restore > fill > freehand.
- IDLE -> LOCK_FILL: fill granted while fill_busy==1.
- LOCK_FILL: only fill granted; restore waits; freehand waits unless aging fires.
- LOCK_FILL -> IDLE: any edge where fill_busy==0 (a grant issued in that same cycle still completes).
- Output register: on grant, loads x/y/color/src, out_valid=1. On out_ready with no new grant, out_valid=0. Grant and out_ready together: new pixel replaces old, out_valid stays 1. out_x/y/color/src hold last value when out_valid==0.
- out_ready while out_valid==0: ignored.
- Aging (if compiled): counter age increments each LOCK_FILL cycle with free_req==1 and no free_gnt, saturating at AGE_LIMIT; cleared on free_gnt, free_req==0, or in IDLE. When age==AGE_LIMIT and slot open, free_gnt issued instead of fill_gnt; lock retained.

## Timing
- Reset values: all gnt=0, out_valid=0, out_x=out_y=0, out_color=0, out_src=0, lock_active=0, state IDLE, age=0.
- Latency: req with open slot -> gnt same cycle -> out_valid next cycle (1 cycle).
- Throughput: one pixel per cycle with out_ready held high.
- Back-pressure: out_valid held, output data stable until out_ready.
- Reset mid-operation: held pixel discarded, lock and age cleared; requesters re-request.

## Configuration
- PIXEL_SCHED_AGING_EN defined: age counter and forced freehand grant as above.
- Undefined: no counter; freehand only served in IDLE; behaviour otherwise identical.

## Test plan
- Reset, then free_req with (10,20,color 5), out_ready=1 -> free_gnt same cycle; next cycle out_valid=1, out=(10,20,5), out_src=2.
- rst_req, fill_req, free_req raised together in IDLE, fill_busy=0 -> order restore, fill, freehand on three consecutive cycles.
- fill_busy=1, 4 fill pixels, rst_req raised after first -> lock_active=1, all 4 fill pixels out contiguously; restore granted in cycle after fill_busy falls.
- out_ready=0 with out_valid=1 for 5 cycles -> no grants, output stable; out_ready=1 -> next grant same cycle.
- Aging, AGE_LIMIT=4: long fill lock, free_req held -> free_gnt after 4 waiting cycles, lock_active stays 1; without macro free_gnt only after fill_busy falls.
- rst asserted while out_valid=1 and lock_active=1 -> out_valid=0, lock_active=0 immediately (asynchronous).
